// File: rtl/signed_div_pow2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signed_div_pow2_pkg
// Description : Shared payload type and bias helper for signed_div_pow2_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package signed_div_pow2_pkg;

    // Operand width carried by the stage-1 payload; the pipe's N must match it.
    localparam int unsigned PAYLOAD_W = 8;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] x;
        logic [PAYLOAD_W-1:0] biased;
    } stage1_t;

    // Adding 2**s-1 to negative operands turns the floor of an arithmetic
    // shift into truncation toward zero.
    function automatic logic [PAYLOAD_W-1:0] bias_for(
        input logic [PAYLOAD_W-1:0] x,
        input int unsigned          s
    );
        logic [PAYLOAD_W-1:0] mask;
        mask     = PAYLOAD_W'((64'd1 << s) - 64'd1);
        bias_for = ($signed(x) < 0) ? mask : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready register slice; accepts whenever empty or draining.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import signed_div_pow2_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         w_load;

    assign ready_o = ~valid_q | ready_i;
    assign w_load  = valid_i & ready_o;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
        end
        if (w_load) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/signed_div_pow2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : signed_div_pow2_pipe
// Description : Two-stage signed divide by 2**S, truncating toward zero.
//               Define SIGNED_DIV_POW2_REM_EN to add the down_rem output.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_div_pow2_pipe
    import signed_div_pow2_pkg::*;
#(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [N-1:0] up_data,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [N-1:0] down_quot
`ifdef SIGNED_DIV_POW2_REM_EN
    ,
    output logic [N-1:0] down_rem
`endif
);

    if ((S < 1) || (S > N - 1)) begin : g_bad_shift
        $error("signed_div_pow2_pipe: S must lie in 1..N-1");
    end
    if (N != int'(PAYLOAD_W)) begin : g_bad_width
        $error("signed_div_pow2_pipe: N must equal the package PAYLOAD_W");
    end

`ifdef SIGNED_DIV_POW2_REM_EN
    localparam int S1_W = $bits(stage1_t);
    localparam int S2_W = 2 * N;
`else
    localparam int S1_W = N;
    localparam int S2_W = N;
`endif

    logic            w_s1_valid;
    logic            w_s2_ready;
    logic [N-1:0]    w_biased;
    logic [N-1:0]    w_s1_biased;
    logic [N-1:0]    w_q_d;
    logic [S2_W-1:0] w_s2_d;
    logic [S2_W-1:0] w_s2_q;

    // Stage 1: bias negative operands so the later shift truncates toward zero.
    assign w_biased = N'(up_data + bias_for(up_data, S));

`ifdef SIGNED_DIV_POW2_REM_EN
    stage1_t      w_s1_d;
    stage1_t      w_s1_q;
    logic [N-1:0] w_rem_d;

    assign w_s1_d.x      = up_data;
    assign w_s1_d.biased = w_biased;
    assign w_s1_biased   = w_s1_q.biased;
`else
    logic [S1_W-1:0] w_s1_d;
    logic [S1_W-1:0] w_s1_q;

    assign w_s1_d      = w_biased;
    assign w_s1_biased = w_s1_q;
`endif

    pipe_stage_reg #(
        .W (S1_W)
    ) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (up_valid),
        .ready_o (up_ready),
        .data_i  (w_s1_d),
        .valid_o (w_s1_valid),
        .ready_i (w_s2_ready),
        .data_o  (w_s1_q)
    );

    // Stage 2: arithmetic shift of the biased operand.
    assign w_q_d = {{S{w_s1_biased[N-1]}}, w_s1_biased[N-1:S]};

`ifdef SIGNED_DIV_POW2_REM_EN
    assign w_rem_d = N'(w_s1_q.x - (w_q_d << S));
    assign w_s2_d  = {w_q_d, w_rem_d};
`else
    assign w_s2_d  = w_q_d;
`endif

    pipe_stage_reg #(
        .W (S2_W)
    ) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (w_s1_valid),
        .ready_o (w_s2_ready),
        .data_i  (w_s2_d),
        .valid_o (down_valid),
        .ready_i (down_ready),
        .data_o  (w_s2_q)
    );

`ifdef SIGNED_DIV_POW2_REM_EN
    assign down_quot = w_s2_q[S2_W-1:N];
    assign down_rem  = w_s2_q[N-1:0];
`else
    assign down_quot = w_s2_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_signed_div_pow2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_div_pow2_pipe
// Description : Directed bench for signed_div_pow2_pipe with N=8, S=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_div_pow2_pipe;

    localparam int N = 8;
    localparam int S = 3;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         up_valid   = 1'b0;
    logic         down_ready = 1'b0;
    logic [N-1:0] up_data    = '0;
    logic         up_ready;
    logic         down_valid;
    logic [N-1:0] down_quot;
`ifdef SIGNED_DIV_POW2_REM_EN
    logic [N-1:0] down_rem;
`endif

    int checks = 0;
    int errors = 0;
    int xs[$];
    int qs[$];
    int rs[$];
    int sb[$];

    signed_div_pow2_pipe #(
        .N (N),
        .S (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_quot  (down_quot)
`ifdef SIGNED_DIV_POW2_REM_EN
        ,
        .down_rem   (down_rem)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams xs back-to-back with down_ready high; result i must be visible
    // right after the edge following its acceptance edge.
    task automatic run_stream(input string tag);
        down_ready = 1'b1;
        for (int i = 0; i <= xs.size(); i++) begin
            up_valid = (i < xs.size());
            up_data  = (i < xs.size()) ? N'(xs[i]) : '0;
            #1;
            if (i < xs.size()) check({tag, "_up_ready"}, 32'(up_ready), 1);
            step();
            if (i == 0) begin
                check({tag, "_lat_valid0"}, 32'(down_valid), 0);
            end else begin
                check({tag, "_valid"}, 32'(down_valid), 1);
                check({tag, "_quot"}, $signed(down_quot), qs[i-1]);
`ifdef SIGNED_DIV_POW2_REM_EN
                check({tag, "_rem"}, $signed(down_rem), rs[i-1]);
`endif
            end
        end
        up_valid = 1'b0;
        step();
        check({tag, "_drained"}, 32'(down_valid), 0);
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        int ex;

        // Reset state, observed before any clock edge.
        #1;
        check("rst_down_valid", 32'(down_valid), 0);
        check("rst_up_ready", 32'(up_ready), 1);
        check("rst_quot", $signed(down_quot), 0);
`ifdef SIGNED_DIV_POW2_REM_EN
        check("rst_rem", $signed(down_rem), 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Negative operands, including the most-negative value.
        xs = {-7, -8, -9, 127, -128};
        qs = {0, -1, -1, 15, -16};
        rs = {-7, 0, -1, 7, 0};
        run_stream("neg");

        // Non-negative operands must agree with a plain arithmetic shift.
        xs = {0, 7, 8, 64};
        qs = {xs[0] >>> S, xs[1] >>> S, xs[2] >>> S, xs[3] >>> S};
        rs = {0, 7, 0, 0};
        run_stream("pos");
        check("pos_hand_q3", qs[3], 8);

        // Backpressure: two samples fill the pipe, then up_ready drops.
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = 8'd16;
        #1 check("bp_rdy_a", 32'(up_ready), 1);
        step();
        up_data = 8'd24;
        #1 check("bp_rdy_b", 32'(up_ready), 1);
        step();
        check("bp_valid", 32'(down_valid), 1);
        check("bp_quot_a", $signed(down_quot), 2);
        up_data = 8'd32;
        #1 check("bp_rdy_c", 32'(up_ready), 0);
        step();
        check("bp_quot_hold_c", $signed(down_quot), 2);
        up_data = 8'd40;
        #1 check("bp_rdy_d", 32'(up_ready), 0);
        step();
        check("bp_quot_hold_d", $signed(down_quot), 2);
        check("bp_valid_hold", 32'(down_valid), 1);
        down_ready = 1'b1;
        up_data    = 8'd32;
        #1 check("bp_rdy_rel", 32'(up_ready), 1);
        check("bp_quot_out2", $signed(down_quot), 2);
        step();
        check("bp_quot_out3", $signed(down_quot), 3);
        up_data = 8'd40;
        step();
        check("bp_quot_out4", $signed(down_quot), 4);
        up_valid = 1'b0;
        step();
        check("bp_quot_out5", $signed(down_quot), 5);
        check("bp_valid_out5", 32'(down_valid), 1);
        step();
        check("bp_drained", 32'(down_valid), 0);

        // Random handshakes against a scoreboard of accepted operands.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((got < 1000) && (cyc < 20000)) begin
            up_valid   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            up_data    = N'($urandom);
            down_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (up_valid && up_ready) begin
                sb.push_back(int'($signed(up_data)));
                sent++;
            end
            if (down_valid && down_ready) begin
                ex = (sb.size() > 0) ? sb.pop_front() : 32'sh7fff;
                check("rand_quot", $signed(down_quot), ex / 8);
`ifdef SIGNED_DIV_POW2_REM_EN
                check("rand_rem", $signed(down_rem), ex % 8);
                check("rand_recon", $signed(down_quot) * 8 + $signed(down_rem), ex);
`endif
                got++;
            end
            step();
            cyc++;
        end
        check("rand_count", got, 1000);
        check("rand_sb_empty", sb.size(), 0);

        // Mid-stream reset: both stages full, then discarded asynchronously.
        up_valid   = 1'b1;
        down_ready = 1'b0;
        up_data    = 8'd40;
        step();
        up_data = 8'(-40);
        step();
        up_valid = 1'b0;
        check("mrst_full_valid", 32'(down_valid), 1);
        check("mrst_full_rdy", 32'(up_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(down_valid), 0);
        check("mrst_up_ready", 32'(up_ready), 1);
        check("mrst_quot", $signed(down_quot), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = 8'(-20);
        step();
        up_valid = 1'b0;
        check("mrst_no_stale", 32'(down_valid), 0);
        step();
        check("mrst_first_valid", 32'(down_valid), 1);
        check("mrst_first_quot", $signed(down_quot), -2);
`ifdef SIGNED_DIV_POW2_REM_EN
        check("mrst_first_rem", $signed(down_rem), -4);
`endif
        step();
        check("mrst_drained", 32'(down_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
